// File: rtl/axil_pattern_checker_master.sv
// AXI4-Lite test master: writes N pattern words into a slave window, reads them back and
// compares, reporting completion, a sticky error flag and a saturating error count.
module axil_pattern_checker_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = C_M_AXI_ADDR_WIDTH'(32'h4000_0000),
  parameter int C_M_TRANSACTIONS_NUM = 4,
  parameter int C_PATTERN_MODE = 0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_XOR_KEY = {(C_M_AXI_DATA_WIDTH/32){32'hA5A5_A5A5}}
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            INIT_AXI_TXN,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   SEED,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [7:0]                      ERR_CNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int N     = C_M_TRANSACTIONS_NUM;
  localparam int IW    = $clog2(N + 1);
  localparam int SHIFT = $clog2(DW / 8);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg;
  logic            busy_reg;
  logic            init_d_reg;
  logic [DW-1:0]   seed_reg;
  logic            awvalid_reg, wvalid_reg, arvalid_reg;
  logic [AW-1:0]   awaddr_reg, araddr_reg;
  logic [DW-1:0]   wdata_reg;
  logic            error_reg;
  logic [7:0]      err_cnt_reg;

  logic            start, start_ok;
  logic            b_hs, r_hs, last, issue_w, issue_r, beat_err;
  logic [DW-1:0]   word_value, exp_data;
  logic [AW-1:0]   word_addr;
  logic            unused_resp_lsb;

  assign start    = INIT_AXI_TXN & ~init_d_reg;
  assign start_ok = start && (state_reg == IDLE || state_reg == DONE);
  assign b_hs     = M_AXI_BVALID && M_AXI_BREADY;
  assign r_hs     = M_AXI_RVALID && M_AXI_RREADY;
  assign last     = (idx_reg == IW'(N - 1));
  assign issue_w  = (state_reg == WRITE) && !busy_reg;
  assign issue_r  = (state_reg == READ) && !busy_reg;

  // The same expression serves both the written data and the read-back compare.
  assign word_value = seed_reg + DW'(idx_reg);
  assign exp_data   = (C_PATTERN_MODE == 1) ? (word_value ^ C_XOR_KEY) : word_value;
  assign word_addr  = C_M_TARGET_SLAVE_BASE_ADDR + (AW'(idx_reg) << SHIFT);

  // Only the error bit of each response matters (SLVERR/DECERR).
  assign beat_err = (b_hs && M_AXI_BRESP[1]) ||
                    (r_hs && (M_AXI_RRESP[1] || (M_AXI_RDATA != exp_data)));
  assign unused_resp_lsb = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = WRITE;
      WRITE:   if (b_hs && last) state_next = READ;
      READ:    if (r_hs && last) state_next = DONE;
      DONE:    if (start) state_next = WRITE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    TXN_DONE     = (state_reg == DONE);
    M_AXI_BREADY = (state_reg == WRITE) && busy_reg;
    M_AXI_RREADY = (state_reg == READ) && busy_reg;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      idx_reg     <= '0;
      busy_reg    <= 1'b0;
      init_d_reg  <= 1'b0;
      seed_reg    <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      awaddr_reg  <= '0;
      araddr_reg  <= '0;
      wdata_reg   <= '0;
      error_reg   <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      init_d_reg <= INIT_AXI_TXN;

      if (start_ok) begin
        seed_reg    <= SEED;
        idx_reg     <= '0;
        busy_reg    <= 1'b0;
        error_reg   <= 1'b0;
        err_cnt_reg <= '0;
      end

      // AW and W launch together; each drops independently on its own handshake.
      if (issue_w) begin
        awvalid_reg <= 1'b1;
        wvalid_reg  <= 1'b1;
        awaddr_reg  <= word_addr;
        wdata_reg   <= exp_data;
        busy_reg    <= 1'b1;
      end else begin
        if (awvalid_reg && M_AXI_AWREADY) awvalid_reg <= 1'b0;
        if (wvalid_reg && M_AXI_WREADY)   wvalid_reg  <= 1'b0;
      end

      if (issue_r) begin
        arvalid_reg <= 1'b1;
        araddr_reg  <= word_addr;
        busy_reg    <= 1'b1;
      end else if (arvalid_reg && M_AXI_ARREADY) begin
        arvalid_reg <= 1'b0;
      end

      if (b_hs || r_hs) begin
        busy_reg <= 1'b0;
        idx_reg  <= last ? '0 : idx_reg + IW'(1);
      end

      if (beat_err) begin
        error_reg <= 1'b1;
        if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign ERROR         = error_reg;
  assign ERR_CNT       = err_cnt_reg;
  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_ARADDR  = araddr_reg;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_reg;

endmodule

// File: tb/tb_axil_pattern_checker_master.sv
// Bench: two masters (incrementing and XOR-keyed pattern) against memory slaves with
// optional ready skew and injected faults; results compared with a plain-arithmetic model.
module tb_axil_pattern_checker_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] KEY  = 32'hA5A5_A5A5;
  localparam int          N    = 4;

  typedef struct {
    logic [31:0] seed;
    bit          skew;
    int          corrupt_idx;
    int          bresp_idx;
    int          rresp_idx;
    int          exp_err;
  } vec_t;

  logic        clk, rst, init_txn;
  logic [31:0] seed_in;
  bit          skew_en, stat_clr;
  int          corrupt_idx, bresp_idx, rresp_idx;

  logic [1:0]  txn_done, error, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  arvalid, arready, rvalid, rready;
  logic [7:0]  err_cnt [2];
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
  logic [2:0]  awprot [2], arprot [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  bresp [2], rresp [2];

  logic [1:0]  aw_got, w_got, prv_aw, prv_w, prv_ar;
  logic [31:0] aw_l [2], w_l [2], prv_awaddr [2], prv_wdata [2], prv_araddr [2];
  logic [31:0] mem [2][8];
  int          aw_cnt [2], w_cnt [2], b_cnt [2], ar_cnt [2], r_cnt [2];
  int          stab_err [2], addr_err [2];

  int tests = 0;
  int fails = 0;
  vec_t vecs [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    axil_pattern_checker_master #(
      .C_PATTERN_MODE(gi),
      .C_XOR_KEY(KEY)
    ) u_dut (
      .ACLK(clk), .ARESET(rst), .INIT_AXI_TXN(init_txn), .SEED(seed_in),
      .TXN_DONE(txn_done[gi]), .ERROR(error[gi]), .ERR_CNT(err_cnt[gi]),
      .M_AXI_AWADDR(awaddr[gi]), .M_AXI_AWPROT(awprot[gi]),
      .M_AXI_AWVALID(awvalid[gi]), .M_AXI_AWREADY(awready[gi]),
      .M_AXI_WDATA(wdata[gi]), .M_AXI_WSTRB(wstrb[gi]),
      .M_AXI_WVALID(wvalid[gi]), .M_AXI_WREADY(wready[gi]),
      .M_AXI_BRESP(bresp[gi]), .M_AXI_BVALID(bvalid[gi]), .M_AXI_BREADY(bready[gi]),
      .M_AXI_ARADDR(araddr[gi]), .M_AXI_ARPROT(arprot[gi]),
      .M_AXI_ARVALID(arvalid[gi]), .M_AXI_ARREADY(arready[gi]),
      .M_AXI_RDATA(rdata[gi]), .M_AXI_RRESP(rresp[gi]),
      .M_AXI_RVALID(rvalid[gi]), .M_AXI_RREADY(rready[gi])
    );
  end

  // Memory slave per master, with handshake counting and VALID-stability tracking.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        awready[k] <= 1'b0; wready[k] <= 1'b0; arready[k] <= 1'b0;
        bvalid[k] <= 1'b0; rvalid[k] <= 1'b0; bresp[k] <= 2'b00; rresp[k] <= 2'b00;
        rdata[k] <= '0; aw_got[k] <= 1'b0; w_got[k] <= 1'b0;
        prv_aw[k] <= 1'b0; prv_w[k] <= 1'b0; prv_ar[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        awready[k] <= skew_en ? ($urandom_range(0, 3) == 0) : 1'b1;
        wready[k]  <= skew_en ? ($urandom_range(0, 3) == 0) : 1'b1;
        arready[k] <= skew_en ? ($urandom_range(0, 3) == 0) : 1'b1;

        prv_aw[k] <= awvalid[k] && !awready[k];
        prv_w[k]  <= wvalid[k] && !wready[k];
        prv_ar[k] <= arvalid[k] && !arready[k];
        prv_awaddr[k] <= awaddr[k];
        prv_wdata[k]  <= wdata[k];
        prv_araddr[k] <= araddr[k];
        stab_err[k] <= stab_err[k]
          + int'(prv_aw[k] && (!awvalid[k] || awaddr[k] != prv_awaddr[k]))
          + int'(prv_w[k]  && (!wvalid[k]  || wdata[k]  != prv_wdata[k]))
          + int'(prv_ar[k] && (!arvalid[k] || araddr[k] != prv_araddr[k]));

        aw_cnt[k] <= aw_cnt[k] + int'(awvalid[k] && awready[k]);
        w_cnt[k]  <= w_cnt[k]  + int'(wvalid[k] && wready[k]);
        ar_cnt[k] <= ar_cnt[k] + int'(arvalid[k] && arready[k]);
        addr_err[k] <= addr_err[k]
          + int'(aw_got[k] && w_got[k] && !bvalid[k] && aw_l[k] != BASE + 32'(b_cnt[k] * 4))
          + int'(arvalid[k] && arready[k] && araddr[k] != BASE + 32'(ar_cnt[k] * 4));

        if (awvalid[k] && awready[k] && !aw_got[k]) begin
          aw_got[k] <= 1'b1;
          aw_l[k]   <= awaddr[k];
        end
        if (wvalid[k] && wready[k] && !w_got[k]) begin
          w_got[k] <= 1'b1;
          w_l[k]   <= wdata[k];
        end
        if (aw_got[k] && w_got[k] && !bvalid[k]) begin
          bvalid[k] <= 1'b1;
          bresp[k]  <= (b_cnt[k] == bresp_idx) ? 2'b10 : 2'b00;
          mem[k][aw_l[k][4:2]] <= w_l[k];
        end
        if (bvalid[k] && bready[k]) begin
          bvalid[k] <= 1'b0;
          aw_got[k] <= 1'b0;
          w_got[k]  <= 1'b0;
          b_cnt[k]  <= b_cnt[k] + 1;
        end

        if (arvalid[k] && arready[k] && !rvalid[k]) begin
          rvalid[k] <= 1'b1;
          rdata[k]  <= mem[k][araddr[k][4:2]] ^ {31'b0, (r_cnt[k] == corrupt_idx)};
          rresp[k]  <= (r_cnt[k] == rresp_idx) ? 2'b11 : 2'b00;
        end
        if (rvalid[k] && rready[k]) begin
          rvalid[k] <= 1'b0;
          r_cnt[k]  <= r_cnt[k] + 1;
        end

        if (stat_clr) begin
          aw_cnt[k] <= 0; w_cnt[k] <= 0; b_cnt[k] <= 0; ar_cnt[k] <= 0; r_cnt[k] <= 0;
          stab_err[k] <= 0; addr_err[k] <= 0;
          for (int j = 0; j < 8; j++) mem[k][j] <= '0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] s, input int i);
    logic [31:0] w;
    w = s + 32'(i);
    return (k == 1) ? (w ^ KEY) : w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic clear_stats();
    @(negedge clk) stat_clr = 1'b1;
    @(negedge clk) stat_clr = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] s, input string nm);
    seed_in  = s;
    init_txn = 1'b1;
    @(negedge clk) init_txn = 1'b0;
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s_m%0d_start_clear", nm, k), {txn_done[k], error[k], err_cnt[k]}, 0);
  endtask

  task automatic wait_done();
    int c = 0;
    while (txn_done != 2'b11 && c < 3000) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic check_run(input string nm, input logic [31:0] s, input int exp_err);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_m%0d_done", nm, k), txn_done[k], 1);
      chk($sformatf("%s_m%0d_error", nm, k), error[k], exp_err != 0);
      chk($sformatf("%s_m%0d_err_cnt", nm, k), err_cnt[k], exp_err);
      for (int i = 0; i < N; i++)
        chk($sformatf("%s_m%0d_mem%0d", nm, k, i), mem[k][i], exp_word(k, s, i));
      chk($sformatf("%s_m%0d_aw_cnt", nm, k), aw_cnt[k], N);
      chk($sformatf("%s_m%0d_w_cnt", nm, k), w_cnt[k], N);
      chk($sformatf("%s_m%0d_b_cnt", nm, k), b_cnt[k], N);
      chk($sformatf("%s_m%0d_ar_cnt", nm, k), ar_cnt[k], N);
      chk($sformatf("%s_m%0d_r_cnt", nm, k), r_cnt[k], N);
      chk($sformatf("%s_m%0d_stable", nm, k), stab_err[k], 0);
      chk($sformatf("%s_m%0d_addr", nm, k), addr_err[k], 0);
      $display("[TB] %s master%0d seed=%08h done=%0b error=%0b err_cnt=%0d", nm, k, s,
               txn_done[k], error[k], err_cnt[k]);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    skew_en     = v.skew;
    corrupt_idx = v.corrupt_idx;
    bresp_idx   = v.bresp_idx;
    rresp_idx   = v.rresp_idx;
    clear_stats();
    start_run(v.seed, nm);
    wait_done();
    check_run(nm, v.seed, v.exp_err);
  endtask

  initial begin
    int c;
    rst = 1'b1; init_txn = 1'b0; seed_in = '0; skew_en = 1'b0; stat_clr = 1'b0;
    corrupt_idx = -1; bresp_idx = -1; rresp_idx = -1;

    //                seed          skew  corrupt bresp rresp exp_err
    vecs[0] = '{32'h0000_0001,      1'b0, -1,     -1,   -1,   0};
    vecs[1] = '{32'hFFFF_FFFE,      1'b0, -1,     -1,   -1,   0};
    vecs[2] = '{32'h0000_0010,      1'b0,  2,     -1,   -1,   1};
    vecs[3] = '{32'h0000_0010,      1'b0, -1,     -1,   -1,   0};
    vecs[4] = '{32'h0000_0005,      1'b0, -1,      0,    3,   2};
    vecs[5] = '{$urandom(),         1'b1, -1,     -1,   -1,   0};
    vecs[6] = '{$urandom(),         1'b1,  1,     -1,    1,   1};
    vecs[7] = '{$urandom(),         1'b1,  0,      3,   -1,   2};
    vecs[8] = '{32'hFFFF_FFFD,      1'b1, -1,     -1,   -1,   0};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_m%0d_status", k), {txn_done[k], error[k], err_cnt[k]}, 0);
      chk($sformatf("reset_m%0d_valids", k), {awvalid[k], wvalid[k], arvalid[k], bready[k], rready[k]}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("idle_m%0d_done", k), txn_done[k], 0);
      chk($sformatf("const_m%0d_prot_strb", k), {awprot[k], arprot[k], wstrb[k]}, 10'h00F);
    end

    for (int v = 0; v < 9; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // A second start edge while busy must not restart the run or re-sample SEED.
    skew_en = 1'b0; corrupt_idx = -1; bresp_idx = -1; rresp_idx = -1;
    clear_stats();
    start_run(32'h0000_1000, "busy");
    repeat (3) @(negedge clk);
    seed_in  = 32'h0000_2000;
    init_txn = 1'b1;
    @(negedge clk) init_txn = 1'b0;
    wait_done();
    check_run("busy", 32'h0000_1000, 0);

    // Reset in the middle of the write phase drops VALIDs at once, no completion.
    clear_stats();
    start_run(32'h0000_0042, "rst");
    c = 0;
    while (awvalid != 2'b11 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rst_awvalid_seen", awvalid, 2'b11);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_m%0d_valids_low", k), {awvalid[k], wvalid[k], arvalid[k], bready[k], rready[k]}, 0);
      chk($sformatf("rst_m%0d_done_low", k), txn_done[k], 0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk($sformatf("rst_m%0d_no_completion", k), {txn_done[k], error[k], err_cnt[k]}, 0);
    run_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
